// File: rtl/pt_checker_pkg.sv
// rtl/pt_checker_pkg.sv - shared types and constants for the plaintext checker
package pt_checker_pkg;

    // Scan FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_LEN  = 3'd1,
        GET_LEN = 3'd2,
        SCAN    = 3'd3,
        DONE    = 3'd4
    } ptc_state_t;

    // Plaintext RAM layout: length byte first, characters follow
    localparam logic [7:0] PT_LEN_ADDR   = 8'd0;
    localparam logic [7:0] PT_FIRST_ADDR = 8'd1;

    // Saturating address increment so the read pointer never wraps to the length byte
    function automatic logic [7:0] addr_inc_sat(input logic [7:0] a);
        return (a == 8'hFF) ? a : a + 8'd1;
    endfunction

endpackage

// File: rtl/pt_checker_if.sv
// rtl/pt_checker_if.sv - handshake, result and RAM read-port bundle of the checker
interface pt_checker_if;
    logic       en;
    logic       rdy;
    logic       done;
    logic       valid;
    logic [7:0] bad_idx;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;

    // Controller/RAM side
    modport master (
        output en,
        input  rdy,
        input  done,
        input  valid,
        input  bad_idx,
        input  pt_addr,
        output pt_rddata
    );

    // Checker side
    modport slave (
        input  en,
        output rdy,
        output done,
        output valid,
        output bad_idx,
        output pt_addr,
        input  pt_rddata
    );
endinterface

// File: rtl/pt_checker_char_in_range.sv
// rtl/pt_checker_char_in_range.sv - combinational inclusive range test on one byte
module char_in_range #(
    parameter logic [7:0] LO = 8'h20,
    parameter logic [7:0] HI = 8'h7E
) (
    input  logic [7:0] i_char,
    output logic       o_ok
);

    // Unsigned inclusive compare against both bounds
    always_comb begin
        o_ok = (i_char >= LO) && (i_char <= HI);
    end

endmodule

// File: rtl/pt_checker.sv
// rtl/pt_checker.sv - streaming printable-character check over the decrypted plaintext RAM
module pt_checker
    import pt_checker_pkg::*;
#(
    parameter logic [7:0] LO_CHAR    = 8'h20,
    parameter logic [7:0] HI_CHAR    = 8'h7E,
    parameter bit         EARLY_EXIT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    pt_checker_if.slave   bus
);

    ptc_state_t r_state;
    ptc_state_t w_state_nxt;
    logic [7:0] r_len,      w_len_nxt;
    logic [7:0] r_idx,      w_idx_nxt;
    logic [7:0] r_pt_addr,  w_pt_addr_nxt;
    logic [7:0] r_bad_idx,  w_bad_idx_nxt;
    logic       r_valid,    w_valid_nxt;
    logic       r_bad_seen, w_bad_seen_nxt;
    logic       w_rdy;
    logic       w_done;
    logic       w_char_ok;

    char_in_range #(
        .LO (LO_CHAR),
        .HI (HI_CHAR)
    ) u_range (
        .i_char (bus.pt_rddata),
        .o_ok   (w_char_ok)
    );

    // State and datapath registers; reset discards any scan in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= 8'd0;
            r_idx      <= 8'd0;
            r_pt_addr  <= PT_LEN_ADDR;
            r_bad_idx  <= 8'd0;
            r_valid    <= 1'b0;
            r_bad_seen <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_pt_addr  <= w_pt_addr_nxt;
            r_bad_idx  <= w_bad_idx_nxt;
            r_valid    <= w_valid_nxt;
            r_bad_seen <= w_bad_seen_nxt;
        end
    end

    // Next-state and datapath updates; the address runs one byte ahead of the char being checked
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_pt_addr_nxt  = r_pt_addr;
        w_bad_idx_nxt  = r_bad_idx;
        w_valid_nxt    = r_valid;
        w_bad_seen_nxt = r_bad_seen;
        w_rdy          = 1'b0;
        w_done         = 1'b0;

        case (r_state)
            IDLE: begin
                w_rdy = 1'b1;
                if (bus.en) begin
                    w_valid_nxt    = 1'b0;
                    w_bad_idx_nxt  = 8'd0;
                    w_bad_seen_nxt = 1'b0;
                    w_pt_addr_nxt  = PT_LEN_ADDR;
                    w_state_nxt    = RD_LEN;
                end
            end
            RD_LEN: begin
                w_pt_addr_nxt = PT_FIRST_ADDR;
                w_state_nxt   = GET_LEN;
            end
            GET_LEN: begin
                w_len_nxt     = bus.pt_rddata;
                w_idx_nxt     = 8'd1;
                w_pt_addr_nxt = PT_FIRST_ADDR + 8'd1;
                if (bus.pt_rddata == 8'd0) begin
                    w_valid_nxt = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (!w_char_ok && !r_bad_seen) begin
                    w_bad_seen_nxt = 1'b1;
                    w_bad_idx_nxt  = r_idx;
                end
                if (!w_char_ok && EARLY_EXIT) begin
                    w_state_nxt = DONE;
                end else if (r_idx == r_len) begin
                    w_valid_nxt = w_char_ok && !r_bad_seen;
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt     = r_idx + 8'd1;
                    w_pt_addr_nxt = addr_inc_sat(r_pt_addr);
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.rdy     = w_rdy;
    assign bus.done    = w_done;
    assign bus.valid   = r_valid;
    assign bus.bad_idx = r_bad_idx;
    assign bus.pt_addr = r_pt_addr;

endmodule

// File: tb/tb_pt_checker.sv
// tb/tb_pt_checker.sv - randomized self-checking bench for pt_checker (early-exit and full-scan builds)
module tb_pt_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r_en = 1'b0;
    logic [7:0] mem [256];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pt_checker_if if_a ();
    pt_checker_if if_b ();

    assign if_a.en = r_en;
    assign if_b.en = r_en;

    always @(posedge clk) begin
        if_a.pt_rddata <= mem[if_a.pt_addr];
        if_b.pt_rddata <= mem[if_b.pt_addr];
    end

    pt_checker #(.LO_CHAR(8'h20), .HI_CHAR(8'h7E), .EARLY_EXIT(1'b1)) u_ee (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    pt_checker #(.LO_CHAR(8'h20), .HI_CHAR(8'h7E), .EARLY_EXIT(1'b0)) u_full (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic bit printable(input logic [7:0] c);
        return (c >= 8'd32) && (c <= 8'd126);
    endfunction

    // Reference: done cycle, validity and first bad index from the RAM image alone
    function automatic void model(input bit ee, output int dcyc, output bit v, output int bidx);
        int len;
        len  = int'(mem[0]);
        v    = 1'b1;
        bidx = 0;
        dcyc = len + 3;
        for (int i = 1; i <= len; i++) begin
            if (!printable(mem[i]) && v) begin
                v    = 1'b0;
                bidx = i;
                if (ee) dcyc = i + 3;
            end
        end
    endfunction

    task automatic run_scan(input string tag, input bit hold_en);
        int  exp_ca, exp_cb, exp_ba, exp_bb;
        bit  exp_va, exp_vb;
        int  cyc_a, cyc_b, cyc_a2, n_done_a, n_done_b, limit;
        int  va, vb, ba, bb;
        bit  zero_addr;
        model(1'b1, exp_ca, exp_va, exp_ba);
        model(1'b0, exp_cb, exp_vb, exp_bb);
        cyc_a = -1; cyc_b = -1; cyc_a2 = -1; n_done_a = 0; n_done_b = 0;
        va = -1; vb = -1; ba = -1; bb = -1; zero_addr = 1'b0;
        limit = hold_en ? 2 * exp_ca + 1 : 300;
        @(negedge clk);
        chk({tag, " rdy_before"}, int'(if_a.rdy & if_b.rdy), 1);
        r_en = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_en) r_en = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (if_a.done) begin
                n_done_a++;
                if (cyc_a < 0) begin
                    cyc_a = c; va = int'(if_a.valid); ba = int'(if_a.bad_idx);
                end else if (cyc_a2 < 0) begin
                    cyc_a2 = c;
                end
            end
            if (if_b.done) begin
                n_done_b++;
                if (cyc_b < 0) begin
                    cyc_b = c; vb = int'(if_b.valid); bb = int'(if_b.bad_idx);
                end
            end
            if (c >= 2 && cyc_a < 0 && if_a.pt_addr == 8'd0) zero_addr = 1'b1;
            if (c >= 2 && cyc_b < 0 && if_b.pt_addr == 8'd0) zero_addr = 1'b1;
            if (!hold_en && cyc_a >= 0 && cyc_b >= 0) break;
        end
        r_en = 1'b0;
        chk({tag, " ee_done_cyc"}, cyc_a, exp_ca);
        chk({tag, " ee_valid"}, va, int'(exp_va));
        chk({tag, " ee_bad_idx"}, ba, exp_ba);
        chk({tag, " full_valid"}, vb, int'(exp_vb));
        chk({tag, " full_bad_idx"}, bb, exp_bb);
        chk({tag, " addr_nonzero"}, int'(zero_addr), 0);
        if (hold_en) begin
            chk({tag, " second_done_cyc"}, cyc_a2, 2 * exp_ca + 1);
            chk({tag, " ee_done_pulses"}, n_done_a, 2);
        end else begin
            chk({tag, " full_done_cyc"}, cyc_b, exp_cb);
            chk({tag, " ee_done_pulses"}, n_done_a, 1);
            chk({tag, " full_done_pulses"}, n_done_b, 1);
        end
        @(negedge clk);
        if (hold_en || exp_ca >= exp_cb) chk({tag, " ee_idle_after"}, int'(if_a.rdy && !if_a.done), 1);
        chk({tag, " held_valid"}, int'(if_a.valid), int'(exp_va));
    endtask

    task automatic load_test1();
        mem[0] = 8'h03; mem[1] = 8'h61; mem[2] = 8'h62; mem[3] = 8'h63;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h41;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset rdy", int'(if_a.rdy), 1);
        chk("reset done", int'(if_a.done), 0);
        chk("reset valid", int'(if_a.valid), 0);
        chk("reset bad_idx", int'(if_a.bad_idx), 0);
        chk("reset pt_addr", int'(if_a.pt_addr), 0);
        chk("reset full pt_addr", int'(if_b.pt_addr), 0);

        load_test1();
        run_scan("t1_abc", 1'b0);

        mem[0] = 8'h05; mem[1] = 8'h48; mem[2] = 8'h7F; mem[3] = 8'h69; mem[4] = 8'h00; mem[5] = 8'h21;
        run_scan("t2_early", 1'b0);

        mem[0] = 8'h02; mem[1] = 8'h20; mem[2] = 8'h7E;
        run_scan("t3_edges_ok", 1'b0);
        mem[0] = 8'h01; mem[1] = 8'h1F;
        run_scan("t3_1f", 1'b0);
        mem[0] = 8'h01; mem[1] = 8'hFF;
        run_scan("t3_ff", 1'b0);
        mem[0] = 8'h00;
        run_scan("t3_empty", 1'b0);

        mem[0] = 8'hFF;
        for (int i = 1; i < 256; i++) mem[i] = 8'h41;
        run_scan("t4_len255", 1'b0);
        mem[255] = 8'h7F;
        run_scan("t4_last_bad", 1'b0);

        // Reset lands in cycle 4 of a scan
        load_test1();
        @(negedge clk);
        r_en = 1'b1;
        @(posedge clk);
        #1;
        r_en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5 rdy", int'(if_a.rdy & if_b.rdy), 1);
        chk("t5 done", int'(if_a.done | if_b.done), 0);
        chk("t5 valid", int'(if_a.valid | if_b.valid), 0);
        chk("t5 pt_addr", int'(if_a.pt_addr), 0);
        rst = 1'b0;
        run_scan("t5_after_rst", 1'b0);

        load_test1();
        run_scan("t6_hold_en", 1'b1);

        for (int t = 0; t < 25; t++) begin
            int len;
            len = $urandom_range(0, 24);
            mem[0] = 8'(len);
            for (int i = 1; i <= len; i++) begin
                case ($urandom_range(0, 11))
                    0: mem[i] = 8'h00;
                    1: mem[i] = 8'h1F;
                    2: mem[i] = 8'h7F;
                    3: mem[i] = 8'(128 + $urandom_range(0, 127));
                    4: mem[i] = 8'h20;
                    5: mem[i] = 8'h7E;
                    default: mem[i] = 8'($urandom_range(32, 126));
                endcase
            end
            run_scan($sformatf("rand%0d", t), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
